// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demux: frame-marker lock, per-channel sample registers and strobes
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_frame_start,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      ch         <= '0;
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_frame_start) begin
              out_data[0 +: W] <= in_data;
              out_valid[0]     <= 1'b1;
              ch               <= CW'(1);
              state            <= LOCKED;
              locked           <= 1'b1;
            end
          end
          LOCKED: begin
            if (in_frame_start) begin
              // An early marker truncates the frame and restarts at channel 0
              sync_err         <= (ch != '0);
              out_data[0 +: W] <= in_data;
              out_valid[0]     <= 1'b1;
              ch               <= CW'(1);
            end else if (ch == '0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
              ch       <= '0;
            end else begin
              out_data[ch*W +: W] <= in_data;
              out_valid[ch]       <= 1'b1;
              if (ch == LAST_CH) begin
                frame_done <= 1'b1;
                ch         <= '0;
              end else begin
                ch <= ch + CW'(1);
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            ch     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux against a frame-position model
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int VW   = N_CH*W + N_CH + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_frame_start = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame position and per-channel last sample
  logic [W-1:0]    m_data [N_CH];
  bit              m_locked;
  int              m_pos;
  logic [N_CH-1:0] e_valid;
  bit              e_done;
  bit              e_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_frame_start(in_frame_start),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {out_data, out_valid, frame_done, sync_err, locked};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N_CH*W-1:0] d;
    for (int k = 0; k < N_CH; k++) d[k*W +: W] = m_data[k];
    return {d, e_valid, e_done, e_err, m_locked};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) m_data[k] = '0;
    m_locked = 0; m_pos = 0; e_valid = '0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
    e_valid = '0; e_done = 0; e_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_data[0] = d; e_valid[0] = 1'b1; m_pos = 1; m_locked = 1;
      end
    end else if (fs) begin
      e_err = (m_pos != 0);
      m_data[0] = d; e_valid[0] = 1'b1; m_pos = 1;
    end else if (m_pos == 0) begin
      e_err = 1; m_locked = 0;
    end else begin
      m_data[m_pos] = d; e_valid[m_pos] = 1'b1;
      e_done = (m_pos == N_CH - 1);
      m_pos = (m_pos + 1) % N_CH;
    end
  endtask

  task automatic drive(input bit v, input bit fs, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v; in_frame_start = fs; in_data = d;
    @(posedge clk);
    #1;
    model_step(v, fs, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL reset_state got %h exp 0", dut_vec());
    end
  endtask

  task automatic test_clean_frame();
    logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, words[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec() || out_valid !== N_CH'(1 << i) || locked !== 1'b1) begin
        n_bad++; $display("FAIL clean_w%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (out_data !== 32'h44332211 || frame_done !== 1'b1 || sync_err !== 1'b0) begin
      n_bad++; $display("FAIL clean_final got data=%h done=%b err=%b exp 44332211/1/0",
                        out_data, frame_done, sync_err);
    end
  endtask

  task automatic test_prelock_garbage();
    logic [W-1:0] words [6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 2, words[i]);
      n_cmp++;
      if (dut_vec() !== exp_vec() || (i < 2 && (out_valid !== '0 || sync_err !== 1'b0))) begin
        n_bad++; $display("FAIL prelock_w%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (out_data !== 32'h04030201) begin
      n_bad++; $display("FAIL prelock_final got %h exp 04030201", out_data);
    end
  endtask

  task automatic test_gaps();
    int dones = 0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1, i == 0, W'(8'h10 * (f + 1) + i));
        if (frame_done) dones++;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL gaps_f%0d_w%0d got %h exp %h", f, i, dut_vec(), exp_vec());
        end
        drive(0, 1, 8'hEE);
        n_cmp++;
        if (dut_vec() !== exp_vec() || out_valid !== '0) begin
          n_bad++; $display("FAIL gaps_idle_f%0d_w%0d got %h exp %h", f, i, dut_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (out_data !== 32'h23222120 || dones !== 2) begin
      n_bad++; $display("FAIL gaps_final got data=%h dones=%0d exp 23222120/2", out_data, dones);
    end
  endtask

  task automatic test_early_marker();
    logic [W-1:0] words [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
    int dones = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, i == 0 || i == 2, words[i]);
      if (frame_done && i < 3) dones++;
      n_cmp++;
      if (dut_vec() !== exp_vec() || locked !== 1'b1) begin
        n_bad++; $display("FAIL early_w%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
      if (i == 2) begin
        n_cmp++;
        if (sync_err !== 1'b1 || out_valid !== 4'b0001) begin
          n_bad++; $display("FAIL early_marker got err=%b valid=%b exp 1/0001", sync_err, out_valid);
        end
      end
    end
    n_cmp++;
    if (out_data !== 32'h23222120 || dones !== 0) begin
      n_bad++; $display("FAIL early_final got data=%h dones=%0d exp 23222120/0", out_data, dones);
    end
  endtask

  task automatic test_missing_marker();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, i == 0, W'(8'h30 + i));
    drive(1, 0, 8'h55);
    n_cmp++;
    if (dut_vec() !== exp_vec() || sync_err !== 1'b1 || locked !== 1'b0 || out_data !== 32'h33323130) begin
      n_bad++; $display("FAIL missing_marker got %h exp %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, W'(8'h60 + i));
      n_cmp++;
      if (dut_vec() !== exp_vec() || out_valid !== '0 || sync_err !== 1'b0) begin
        n_bad++; $display("FAIL missing_ignore_w%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    drive(1, 1, 8'h70);
    n_cmp++;
    if (dut_vec() !== exp_vec() || locked !== 1'b1) begin
      n_bad++; $display("FAIL missing_relock got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive(1, 1, 8'hC0);
    drive(1, 0, 8'hC1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL async_reset got %h exp 0", dut_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, W'(8'hD0 + i));
      n_cmp++;
      if (dut_vec() !== exp_vec() || out_valid !== '0) begin
        n_bad++; $display("FAIL post_reset_w%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 3) != 0);
      fs = (m_pos == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
      drive(v, fs, W'($urandom));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random_%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_frame();
    test_prelock_garbage();
    test_gaps();
    test_early_marker();
    test_missing_marker();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
